// File: rtl/remote_credits_rd_tcp.sv
// Receive-side TCP credit engine: issues read-package requests only when the RX buffer has room,
// buffers returned payload and routes each package to a user stream. Optional stats: TCP_RX_STATS_EN.
module remote_credits_rd_tcp #(
    parameter int N_DESTS       = 1,
    parameter int FIFO_DEPTH    = 64,
    parameter int MAX_PKG_BYTES = 4096,
    parameter int RQ_DEPTH      = 8,
    parameter int DEST_BITS     = (N_DESTS > 1) ? $clog2(N_DESTS) : 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_notify_valid,
    output logic                 s_notify_ready,
    input  logic [15:0]          s_notify_sid,
    input  logic [15:0]          s_notify_len,
    input  logic [DEST_BITS-1:0] s_notify_dest,
    output logic                 m_rd_valid,
    input  logic                 m_rd_ready,
    output logic [15:0]          m_rd_sid,
    output logic [15:0]          m_rd_len,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [511:0]         s_axis_tdata,
    input  logic [63:0]          s_axis_tkeep,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [511:0]         m_axis_tdata,
    output logic [63:0]          m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic [DEST_BITS-1:0] m_axis_tdest
`ifdef TCP_RX_STATS_EN
    ,
    output logic [31:0]          stat_pkgs,
    output logic [31:0]          stat_bytes
`endif
);

    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW  = $clog2(MAX_PKG_BYTES / 64 + 1);
    localparam int QW  = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int QCW = $clog2(RQ_DEPTH + 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t               state;
    logic [15:0]          sid;
    logic [15:0]          rem;
    logic [DEST_BITS-1:0] dest;
    logic [CW-1:0]        credits;
    logic [15:0]          chunk;
    logic [BW-1:0]        beats;
    logic                 rd_hs;
    logic                 in_hs;
    logic                 out_hs;

    // FIFO storage: {tkeep, tdata}
    logic [575:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        fcount;
    logic                 fifo_nempty;

    logic [DEST_BITS-1:0] rq_dest  [RQ_DEPTH];
    logic [BW-1:0]        rq_beats [RQ_DEPTH];
    logic [QW-1:0]        rq_wr;
    logic [QW-1:0]        rq_rd;
    logic [QCW-1:0]       rq_count;
    logic                 rq_full;
    logic                 rq_nempty;
    logic                 rq_pop;
    logic [BW-1:0]        beat_cnt;

    logic                 unused_tlast;
    assign unused_tlast = s_axis_tlast;

    always_comb begin
        chunk = (rem > 16'(MAX_PKG_BYTES)) ? 16'(MAX_PKG_BYTES) : rem;
        beats = BW'((17'(chunk) + 17'd63) >> 6);
    end

    // Request valid depends only on registered state, so it cannot drop before m_rd_ready:
    // credits only shrink and the queue only fills through this very handshake.
    assign rq_full     = (rq_count == QCW'(RQ_DEPTH));
    assign rq_nempty   = (rq_count != '0);
    assign m_rd_valid  = (state == REQ) && (32'(credits) >= 32'(beats)) && !rq_full;
    assign m_rd_sid    = sid;
    assign m_rd_len    = chunk;
    assign rd_hs       = m_rd_valid & m_rd_ready;

    assign fifo_nempty   = (fcount != '0);
    assign s_axis_tready = (fcount != CW'(FIFO_DEPTH));
    assign in_hs         = s_axis_tvalid & s_axis_tready;

    assign m_axis_tvalid = fifo_nempty & rq_nempty;
    assign m_axis_tdata  = mem[rd_ptr][511:0];
    assign m_axis_tkeep  = mem[rd_ptr][575:512];
    assign m_axis_tdest  = rq_dest[rq_rd];
    assign m_axis_tlast  = (BW'(beat_cnt + 1'b1) == rq_beats[rq_rd]);
    assign out_hs        = m_axis_tvalid & m_axis_tready;
    assign rq_pop        = out_hs & m_axis_tlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state          <= IDLE;
            s_notify_ready <= 1'b0;
            sid            <= '0;
            rem            <= '0;
            dest           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_notify_ready <= 1'b1;
                    if (s_notify_valid && s_notify_ready) begin
                        sid  <= s_notify_sid;
                        rem  <= s_notify_len;
                        dest <= s_notify_dest;
                        if (s_notify_len != '0) begin
                            state          <= REQ;
                            s_notify_ready <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (rd_hs) begin
                        rem <= rem - chunk;
                        if (rem == chunk) begin
                            state          <= IDLE;
                            s_notify_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset)
            credits <= CW'(FIFO_DEPTH);
        else
            credits <= credits - (rd_hs ? CW'(beats) : '0) + (out_hs ? CW'(1) : '0);
    end

    always_ff @(posedge aclk) begin
        if (in_hs)
            mem[wr_ptr] <= {s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (in_hs)
                wr_ptr <= wr_ptr + 1'b1;
            if (out_hs)
                rd_ptr <= rd_ptr + 1'b1;
            fcount <= fcount + CW'(in_hs) - CW'(out_hs);
        end
    end

    always_ff @(posedge aclk) begin
        if (rd_hs) begin
            rq_dest[rq_wr]  <= dest;
            rq_beats[rq_wr] <= beats;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rq_wr    <= '0;
            rq_rd    <= '0;
            rq_count <= '0;
            beat_cnt <= '0;
        end else begin
            if (rd_hs)
                rq_wr <= (rq_wr == QW'(RQ_DEPTH - 1)) ? '0 : rq_wr + 1'b1;
            if (rq_pop)
                rq_rd <= (rq_rd == QW'(RQ_DEPTH - 1)) ? '0 : rq_rd + 1'b1;
            rq_count <= rq_count + QCW'(rd_hs) - QCW'(rq_pop);
            if (out_hs)
                beat_cnt <= m_axis_tlast ? '0 : beat_cnt + 1'b1;
        end
    end

`ifdef TCP_RX_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            stat_pkgs  <= '0;
            stat_bytes <= '0;
        end else if (rd_hs) begin
            stat_pkgs  <= stat_pkgs + 32'd1;
            stat_bytes <= stat_bytes + 32'(m_rd_len);
        end
    end
`endif

endmodule

// File: tb/tb_remote_credits_rd_tcp.sv
// Randomized bench for remote_credits_rd_tcp against a package/beat-level reference model.
module tb_remote_credits_rd_tcp;
    localparam int N_DESTS    = 4;
    localparam int FIFO_DEPTH = 64;
    localparam int MAX_PKG    = 4096;
    localparam int RQ_DEPTH   = 8;
    localparam int DB         = 2;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          s_notify_valid = 1'b0;
    logic          s_notify_ready;
    logic [15:0]   s_notify_sid = '0;
    logic [15:0]   s_notify_len = '0;
    logic [DB-1:0] s_notify_dest = '0;
    logic          m_rd_valid;
    logic          m_rd_ready = 1'b0;
    logic [15:0]   m_rd_sid;
    logic [15:0]   m_rd_len;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [511:0]  s_axis_tdata = '0;
    logic [63:0]   s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [511:0]  m_axis_tdata;
    logic [63:0]   m_axis_tkeep;
    logic          m_axis_tlast;
    logic [DB-1:0] m_axis_tdest;
`ifdef TCP_RX_STATS_EN
    logic [31:0]   stat_pkgs;
    logic [31:0]   stat_bytes;
`endif

    always #5 aclk = ~aclk;

    remote_credits_rd_tcp #(
        .N_DESTS(N_DESTS), .FIFO_DEPTH(FIFO_DEPTH), .MAX_PKG_BYTES(MAX_PKG), .RQ_DEPTH(RQ_DEPTH)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_notify_valid(s_notify_valid), .s_notify_ready(s_notify_ready),
        .s_notify_sid(s_notify_sid), .s_notify_len(s_notify_len), .s_notify_dest(s_notify_dest),
        .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_sid(m_rd_sid), .m_rd_len(m_rd_len),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest)
`ifdef TCP_RX_STATS_EN
        , .stat_pkgs(stat_pkgs), .stat_bytes(stat_bytes)
`endif
    );

    typedef struct { logic [15:0] sid; logic [15:0] len; logic [DB-1:0] dest; } req_t;
    typedef struct { logic [511:0] data; logic [63:0] keep; logic last; logic [DB-1:0] dest; } beat_t;

    req_t  req_q[$];    // requests the engine still owes for the current notification
    beat_t stack_q[$];  // beats the stack owes for accepted requests
    beat_t exp_q[$];    // beats sitting in the RX buffer, in output order
    int    credits;
    int    outstanding; // packages requested but not fully delivered
    int unsigned n_pkgs, n_bytes;

    int checks = 0;
    int errors = 0;

    bit          rst_req = 1'b1;
    bit          nt_pending = 1'b0;
    bit          in_done = 1'b0;
    logic [15:0] nt_sid, nt_len;
    logic [DB-1:0] nt_dest;
    int rd_pct = 100, out_pct = 100, in_pct = 100;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int beats_of(input int len);
        return (len + 63) / 64;
    endfunction

    task automatic model_clear();
        req_q.delete(); stack_q.delete(); exp_q.delete();
        credits = FIFO_DEPTH; outstanding = 0; n_pkgs = 0; n_bytes = 0;
        nt_pending = 1'b0; in_done = 1'b0;
        s_notify_valid = 1'b0; s_axis_tvalid = 1'b0;
    endtask

    task automatic step();
        bit rd_hs, out_hs, in_hs, nt_hs, exp_rd;
        req_t r;
        beat_t b;
        int nb, rem, c;
        @(negedge aclk);
        if (areset) begin
            check("rst_rd_valid", m_rd_valid, 1'b0);
            check("rst_axis_tvalid", m_axis_tvalid, 1'b0);
            check("rst_notify_ready", s_notify_ready, 1'b0);
            check("rst_s_tready", s_axis_tready, 1'b1);
`ifdef TCP_RX_STATS_EN
            check("rst_stat_pkgs", stat_pkgs, '0);
            check("rst_stat_bytes", stat_bytes, '0);
`endif
        end else begin
            exp_rd = req_q.size() > 0 && credits >= beats_of(int'(req_q[0].len)) && outstanding < RQ_DEPTH;
            check("rd_valid", m_rd_valid, exp_rd);
            check("notify_ready", s_notify_ready, req_q.size() == 0);
            check("axis_tvalid", m_axis_tvalid, exp_q.size() > 0);
            check("s_tready", s_axis_tready, exp_q.size() < FIFO_DEPTH);
            if (m_rd_valid && req_q.size() > 0) begin
                check("rd_sid", m_rd_sid, req_q[0].sid);
                check("rd_len", m_rd_len, req_q[0].len);
            end
            if (m_axis_tvalid && exp_q.size() > 0) begin
                check("tdata", m_axis_tdata, exp_q[0].data);
                check("tkeep", m_axis_tkeep, exp_q[0].keep);
                check("tlast", m_axis_tlast, exp_q[0].last);
                check("tdest", m_axis_tdest, exp_q[0].dest);
            end
`ifdef TCP_RX_STATS_EN
            check("stat_pkgs", stat_pkgs, n_pkgs);
            check("stat_bytes", stat_bytes, n_bytes);
`endif
        end

        areset = rst_req;
        if (rst_req) begin
            model_clear();
            return;
        end
        m_rd_ready    = ($urandom_range(0, 99) < rd_pct);
        m_axis_tready = ($urandom_range(0, 99) < out_pct);
        if (in_done) begin
            s_axis_tvalid = 1'b0;
            in_done = 1'b0;
        end
        if (!s_axis_tvalid && stack_q.size() > 0 && $urandom_range(0, 99) < in_pct) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = stack_q[0].data;
            s_axis_tkeep  = stack_q[0].keep;
            s_axis_tlast  = 1'($urandom_range(0, 1));
        end
        s_notify_valid = nt_pending;
        s_notify_sid   = nt_sid;
        s_notify_len   = nt_len;
        s_notify_dest  = nt_dest;

        rd_hs  = m_rd_valid && m_rd_ready;
        out_hs = m_axis_tvalid && m_axis_tready;
        in_hs  = s_axis_tvalid && s_axis_tready;
        nt_hs  = s_notify_valid && s_notify_ready;

        if (out_hs && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            credits++;
            if (b.last) outstanding--;
        end
        if (rd_hs && req_q.size() > 0) begin
            r = req_q.pop_front();
            nb = beats_of(int'(r.len));
            credits -= nb;
            outstanding++;
            n_pkgs++;
            n_bytes += r.len;
            for (int i = 0; i < nb; i++) begin
                for (int k = 0; k < 16; k++) b.data[k*32 +: 32] = $urandom;
                b.keep = '1;
                if (i == nb - 1 && (r.len % 64) != 0)
                    b.keep = (64'd1 << (r.len % 64)) - 64'd1;
                b.last = (i == nb - 1);
                b.dest = r.dest;
                stack_q.push_back(b);
            end
        end
        if (in_hs && stack_q.size() > 0) begin
            exp_q.push_back(stack_q.pop_front());
            in_done = 1'b1;
        end
        if (nt_hs) begin
            nt_pending = 1'b0;
            rem = nt_len;
            while (rem > 0) begin
                c = (rem > MAX_PKG) ? MAX_PKG : rem;
                r.sid = nt_sid; r.len = 16'(c); r.dest = nt_dest;
                req_q.push_back(r);
                rem -= c;
            end
        end
    endtask

    task automatic notify(input int sid, input int len, input int dest);
        nt_sid = 16'(sid); nt_len = 16'(len); nt_dest = DB'(dest);
        nt_pending = 1'b1;
        for (int n = 0; n < 20000 && nt_pending; n++) step();
        check("notify_accept_timeout", nt_pending, 1'b0);
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 20000 && !idle; n++) begin
            step();
            idle = !nt_pending && req_q.size() == 0 && stack_q.size() == 0 && exp_q.size() == 0;
        end
        check("drain_timeout", idle, 1'b1);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
    endtask

    initial begin
        bit hit;
        int len;
        model_clear();
        do_reset();
        step();

        notify(5, 4096, 0);
        drain();
        notify(6, 10000, 1);
        drain();

        // Output stalled: second 4096 request must wait for the first package to drain
        out_pct = 0;
        notify(7, 4096, 0);
        notify(8, 4096, 1);
        repeat (150) step();
        out_pct = 100;
        drain();

        notify(9, 0, 2);
        repeat (3) step();

        notify(10, 128, 2);
        notify(11, 128, 3);
        drain();

        // Reset while the second request of a 10000-byte notification is pending
        notify(12, 10000, 1);
        hit = 1'b0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            step();
            hit = (req_q.size() == 2);
        end
        check("reset_point_timeout", hit, 1'b1);
        do_reset();
        notify(13, 4096, 0);
        drain();

        for (int t = 0; t < 40; t++) begin
            rd_pct  = $urandom_range(20, 100);
            out_pct = $urandom_range(20, 100);
            in_pct  = $urandom_range(20, 100);
            case ($urandom_range(0, 3))
                0: len = 0;
                1: len = 64 * $urandom_range(1, 140);
                default: len = $urandom_range(1, 9000);
            endcase
            notify($urandom_range(0, 65535), len, $urandom_range(0, N_DESTS - 1));
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
